// File: rtl/lif_pkg.sv
// Shared widths and saturation helpers for the parametrised LIF neuron.
package lif_pkg;

  localparam int unsigned LIF_M  = 8;
  localparam int unsigned LIF_W  = 8;
  localparam int unsigned LIF_VW = 8;
  localparam int unsigned LIF_RW = 8;

  // Clamp a signed value into the range of a signed field of the given width.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int unsigned         width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

  // Clamp a signed value into [0, 2^width-1].
  function automatic logic [63:0] clamp_unsigned(input logic signed [63:0] value,
                                                 input int unsigned         width);
    logic signed [63:0] max_v;
    max_v = (64'sd1 <<< width) - 64'sd1;
    if (value < 64'sd0) begin
      return '0;
    end else if (value > max_v) begin
      return $unsigned(max_v);
    end
    return $unsigned(value);
  endfunction

endpackage

// File: rtl/lif_current_accum.sv
// Stage 1 of the LIF neuron: masked signed sum of the synapse weights, saturated to the
// VW+1 bit signed current and registered on enabled cycles.
module lif_current_accum
  import lif_pkg::*;
#(
  parameter int unsigned M  = LIF_M,
  parameter int unsigned W  = LIF_W,
  parameter int unsigned VW = LIF_VW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [M-1:0]        input_spikes,
  input  logic [M*W-1:0]      weights,
  output logic signed [VW:0]  current_q
);

  // Wide enough that the sum of M full-scale weights can never overflow.
  localparam int unsigned SW = W + $clog2(M) + 1;

  logic signed [SW-1:0] sum;
  logic signed [VW:0]   current_d;

  // Exact signed sum of every weight whose spike bit is set, then saturate.
  always_comb begin
    sum = '0;
    for (int i = 0; i < M; i++) begin
      if (input_spikes[i]) begin
        sum = sum + SW'($signed(weights[i*W +: W]));
      end
    end
    current_d = (VW + 1)'(sat_signed(64'(sum), VW + 1));
  end

  // Current register: cleared by reset, holds while the neuron is paused.
  always_ff @(posedge clk) begin
    if (reset) begin
      current_q <= '0;
    end else if (enable) begin
      current_q <= current_d;
    end
  end

endmodule

// File: rtl/lif_neuron_param.sv
// Parametrised leaky-integrate-and-fire neuron with signed weights, saturating integration,
// a zero floor on the potential and a down-counting refractory period.
// Define LIF_DEBUG_EN to expose the membrane potential on membrane_potential_out.
module lif_neuron_param
  import lif_pkg::*;
#(
  parameter int unsigned M  = LIF_M,
  parameter int unsigned W  = LIF_W,
  parameter int unsigned VW = LIF_VW,
  parameter int unsigned RW = LIF_RW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [M-1:0]    input_spikes,
  input  logic [M*W-1:0]  weights,
  input  logic [VW-1:0]   threshold,
  input  logic [VW-1:0]   decay,
  input  logic [RW-1:0]   refractory_period,
  output logic            spike_out
`ifdef LIF_DEBUG_EN
  ,
  output logic [VW-1:0]   membrane_potential_out
`endif
);

  logic signed [VW:0]   current_q;
  logic [VW-1:0]        v_q, v_d;
  logic [RW-1:0]        refr_q, refr_d;
  logic                 spike_q, spike_d;
  logic signed [VW+1:0] n_raw;
  logic [VW-1:0]        n_clamped;

  lif_current_accum #(
    .M  (M),
    .W  (W),
    .VW (VW)
  ) u_accum (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .input_spikes (input_spikes),
    .weights      (weights),
    .current_q    (current_q)
  );

  // Candidate potential: leak applied after integration, then floored at 0 and capped.
  always_comb begin
    n_raw     = $signed({2'b00, v_q}) + (VW + 2)'(current_q) - $signed({2'b00, decay});
    n_clamped = VW'(clamp_unsigned(64'(n_raw), VW));
  end

  // Stage 2 next state: refractory countdown, fire decision and potential update.
  always_comb begin
    v_d     = v_q;
    refr_d  = refr_q;
    spike_d = 1'b0;
    if (enable) begin
      if (refr_q != '0) begin
        // Silent period: incoming current is discarded, potential pinned to 0.
        refr_d = refr_q - RW'(1);
        v_d    = '0;
      end else if (n_clamped >= threshold) begin
        spike_d = 1'b1;
        v_d     = '0;
        refr_d  = refractory_period;
      end else begin
        v_d = n_clamped;
      end
    end
  end

  // Stage 2 state registers; spike_d is 0 whenever enable is low so pulses never stretch.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q     <= '0;
      refr_q  <= '0;
      spike_q <= 1'b0;
    end else begin
      v_q     <= v_d;
      refr_q  <= refr_d;
      spike_q <= spike_d;
    end
  end

  assign spike_out = spike_q;

`ifdef LIF_DEBUG_EN
  assign membrane_potential_out = v_q;
`endif

endmodule

// File: tb/tb_lif_neuron_param.sv
// Directed scoreboard bench for lif_neuron_param (default M=8, W=8, VW=8, RW=8).
// Stimulus pushes the hand-computed response of each clock edge; a negedge monitor pops and
// compares. The membrane potential is additionally checked when LIF_DEBUG_EN is defined.
module tb_lif_neuron_param;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [7:0]  input_spikes;
  logic [63:0] weights;
  logic [7:0]  threshold;
  logic [7:0]  decay;
  logic [7:0]  refractory_period;
  logic        spike_out;
`ifdef LIF_DEBUG_EN
  logic [7:0]  membrane_potential_out;
`endif

  logic [63:0] wts;

  typedef struct {
    logic       spike;
    logic [7:0] v;
    string      name;
    int         idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_step   = 0;

  lif_neuron_param dut (
    .clk                    (clk),
    .reset                  (reset),
    .enable                 (enable),
    .input_spikes           (input_spikes),
    .weights                (weights),
    .threshold              (threshold),
    .decay                  (decay),
    .refractory_period      (refractory_period),
    .spike_out              (spike_out)
`ifdef LIF_DEBUG_EN
    ,
    .membrane_potential_out (membrane_potential_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight 0, weight 1, and one value shared by weights 2..7.
  function automatic logic [63:0] pack_w(input logic [7:0] w0, input logic [7:0] w1,
                                         input logic [7:0] wr);
    return {wr, wr, wr, wr, wr, wr, w1, w0};
  endfunction

  // Apply one edge of stimulus and queue the expected state after that edge.
  task automatic step(input logic r, input logic en, input logic [7:0] spk,
                      input logic [7:0] thr, input logic [7:0] dec, input logic [7:0] rp,
                      input logic es, input logic [7:0] ev, input string nm);
    exp_t x;
    reset             = r;
    enable            = en;
    input_spikes      = spk;
    threshold         = thr;
    decay             = dec;
    refractory_period = rp;
    weights           = wts;
    @(posedge clk);
    #1;
    n_step++;
    x.spike = es;
    x.v     = ev;
    x.name  = nm;
    x.idx   = n_step;
    exp_q.push_back(x);
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (spike_out === e.spike) n_pass++;
      else $display("FAIL %s step %0d spike_out got %0b want %0b", e.name, e.idx, spike_out,
                    e.spike);
`ifdef LIF_DEBUG_EN
      n_checks++;
      if (membrane_potential_out === e.v) n_pass++;
      else $display("FAIL %s step %0d V got %0d want %0d", e.name, e.idx,
                    membrane_potential_out, e.v);
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Phase A weights: w0=+30, w1=-50, others +127.
    wts = pack_w(8'd30, 8'hCE, 8'd127);
    //   rst en  spikes thr     dec    rp    spk  V
    step(1, 0, 8'h00, 8'd100, 8'd0, 8'd0, 0, 8'd0,   "reset0");
    step(1, 0, 8'h00, 8'd100, 8'd0, 8'd0, 0, 8'd0,   "reset1");
    // Integrate and fire: V = 30, 60, 90, then fire on the fourth real update.
    step(0, 1, 8'h01, 8'd100, 8'd0, 8'd0, 0, 8'd0,   "fill");
    step(0, 1, 8'h01, 8'd100, 8'd0, 8'd0, 0, 8'd30,  "int30");
    step(0, 1, 8'h01, 8'd100, 8'd0, 8'd0, 0, 8'd60,  "int60");
    step(0, 1, 8'h01, 8'd100, 8'd0, 8'd0, 0, 8'd90,  "int90");
    step(0, 1, 8'h01, 8'd100, 8'd0, 8'd0, 1, 8'd0,   "fire");
    step(0, 1, 8'h01, 8'd100, 8'd0, 8'd0, 0, 8'd30,  "after_fire");
    step(0, 1, 8'h01, 8'd100, 8'd0, 8'd0, 0, 8'd60,  "int60b");
    // Reset mid-integration, with a nonzero current pending; probe with threshold 1.
    step(1, 1, 8'h01, 8'd100, 8'd0, 8'd0, 0, 8'd0,   "mid_reset");
    step(0, 1, 8'h00, 8'd1,   8'd0, 8'd0, 0, 8'd0,   "probe_v0");
    step(0, 1, 8'h00, 8'd1,   8'd0, 8'd0, 0, 8'd0,   "probe_v0b");
    // Phase B: w0=+10. Leak 10 -> 6 -> 2 -> 0 -> 0; a wrap to 254 would fire at thr 200.
    wts = pack_w(8'd10, 8'hCE, 8'd127);
    step(0, 1, 8'h01, 8'd200, 8'd0, 8'd0, 0, 8'd0,   "leak_fill");
    step(0, 1, 8'h00, 8'd200, 8'd0, 8'd0, 0, 8'd10,  "leak_v10");
    step(0, 1, 8'h00, 8'd200, 8'd4, 8'd0, 0, 8'd6,   "leak_v6");
    step(0, 1, 8'h00, 8'd200, 8'd4, 8'd0, 0, 8'd2,   "leak_v2");
    step(0, 1, 8'h00, 8'd200, 8'd4, 8'd0, 0, 8'd0,   "floor_v0");
    step(0, 1, 8'h00, 8'd200, 8'd4, 8'd0, 0, 8'd0,   "floor_v0b");
    step(0, 1, 8'h00, 8'd1,   8'd0, 8'd0, 0, 8'd0,   "floor_probe");
    // Inhibitory weight -50 against V=20 floors at 0.
    step(0, 1, 8'h01, 8'd200, 8'd0, 8'd0, 0, 8'd0,   "inh_fill");
    step(0, 1, 8'h01, 8'd200, 8'd0, 8'd0, 0, 8'd10,  "inh_v10");
    step(0, 1, 8'h02, 8'd200, 8'd0, 8'd0, 0, 8'd20,  "inh_v20");
    step(0, 1, 8'h00, 8'd200, 8'd0, 8'd0, 0, 8'd0,   "inh_floor");
    step(0, 1, 8'h00, 8'd1,   8'd0, 8'd0, 0, 8'd0,   "inh_probe");
    // Phase C: all spikes sum to 722, saturating the current at 255. Refractory 3 then 0.
    step(0, 1, 8'hFF, 8'd100, 8'd0, 8'd3, 0, 8'd0,   "refr_fill");
    step(0, 1, 8'hFF, 8'd100, 8'd0, 8'd3, 1, 8'd0,   "refr_fire");
    step(0, 1, 8'hFF, 8'd100, 8'd0, 8'd3, 0, 8'd0,   "refr_q1");
    step(0, 1, 8'hFF, 8'd100, 8'd0, 8'd3, 0, 8'd0,   "refr_q2");
    step(0, 1, 8'hFF, 8'd100, 8'd0, 8'd3, 0, 8'd0,   "refr_q3");
    step(0, 1, 8'hFF, 8'd100, 8'd0, 8'd3, 1, 8'd0,   "refr_refire");
    step(0, 1, 8'hFF, 8'd100, 8'd0, 8'd0, 0, 8'd0,   "refr_q1b");
    step(0, 1, 8'hFF, 8'd100, 8'd0, 8'd0, 0, 8'd0,   "refr_q2b");
    step(0, 1, 8'hFF, 8'd100, 8'd0, 8'd0, 0, 8'd0,   "refr_q3b");
    step(0, 1, 8'hFF, 8'd100, 8'd0, 8'd0, 1, 8'd0,   "b2b_1");
    step(0, 1, 8'hFF, 8'd100, 8'd0, 8'd0, 1, 8'd0,   "b2b_2");
    step(0, 1, 8'hFF, 8'd100, 8'd0, 8'd0, 1, 8'd0,   "b2b_3");
    // Phase D: all weights +127. 200 + 255 clamps to 255 and fires at thr 255 (wrap: 199).
    wts = pack_w(8'd127, 8'd127, 8'd127);
    step(0, 1, 8'hFF, 8'd255, 8'd55, 8'd0, 0, 8'd200, "sat_v200");
    step(0, 1, 8'h00, 8'd255, 8'd0,  8'd0, 1, 8'd0,   "sat_fire");
    // Enable low for 5 cycles: V and pending current hold, no spikes.
    step(0, 1, 8'h01, 8'd200, 8'd0,  8'd0, 0, 8'd0,   "hold_fill");
    step(0, 1, 8'h01, 8'd200, 8'd0,  8'd0, 0, 8'd127, "hold_v127");
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 8'hFF, 8'd0, 8'd50, 8'd0, 0, 8'd127, "hold_off");
    end
    step(0, 1, 8'h00, 8'd255, 8'd0,  8'd0, 0, 8'd254, "hold_resume");
    step(0, 1, 8'h00, 8'd255, 8'd0,  8'd0, 0, 8'd254, "hold_v254");
    step(0, 1, 8'h00, 8'd254, 8'd0,  8'd0, 1, 8'd0,   "thr_live");
    step(0, 0, 8'h00, 8'd254, 8'd0,  8'd0, 0, 8'd0,   "no_stretch");
    // Threshold 0 fires on every non-refractory enabled cycle.
    step(0, 1, 8'h00, 8'd0,   8'd0,  8'd0, 1, 8'd0,   "thr0_a");
    step(0, 1, 8'h00, 8'd0,   8'd0,  8'd0, 1, 8'd0,   "thr0_b");

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain %0d expectations left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
